pac_motion_ctrl: RTL and testbench
==================================

# pac_motion_ctrl

Pac-Man motion controller. It sits directly upstream of the wall-collision checker and owns the sprite's position and heading. On each movement tick it probes the wall ahead through the checker: first in the player's requested direction, then in the current heading. It commits a step only when the probed direction is free. Its position and probe-direction outputs drive the checker's PacX/PacY/state inputs, and its can_move input is the checker's result.

## Interface
- STEP, 2: pixels moved per committed step; legal range 1..3 so the 3-px probe covers it.
- X_INIT, 304: reset X of sprite top-left corner.
- Y_INIT, 224: reset Y of sprite top-left corner.
- X_MAX, 608: largest legal X (640 − 32 sprite width).
- Y_MAX, 448: largest legal Y (480 − 32 sprite height).
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, asynchronous, active-low (0 = reset).
- move_tick  in  1  one-cycle pulse requesting one movement attempt (frame/speed tick).
- req_dir  in  2  player-requested direction; encoding 00 up, 01 down, 10 left, 11 right.
- can_move  in  1  checker result for the probed direction; 1 = no wall.
- pac_x  out  10  sprite X, to checker PacX and renderer.
- pac_y  out  9  sprite Y, to checker PacY and renderer.
- probe_dir  out  2  direction being probed, to checker state.
- heading  out  2  committed heading, to renderer for sprite orientation.
- moving  out  1  1 if the last attempt committed a step.
- busy  out  1  1 whenever the FSM is not in IDLE.
- step_done  out  1  one-cycle pulse at the end of every attempt, whether or not it moved.

## Operation
- The checker registers its probe point one clock after probe_dir/pac_x/pac_y settle. Its result is valid the following cycle. The FSM therefore holds probe_dir and position stable for one WAIT cycle before sampling can_move.
- States: IDLE, WAIT_REQ, CHK_REQ, WAIT_CUR, CHK_CUR.
- IDLE:
  - On move_tick: probe_dir ← req_dir, latch req_dir internally, go to WAIT_REQ.
  - Otherwise stay.
- WAIT_REQ: go to CHK_REQ unconditionally.
- CHK_REQ:
  - If can_move = 1 and the bounds check passes: heading ← latched req, apply step, moving ← 1, step_done ← 1, go to IDLE.
  - Otherwise, if latched req = heading: moving ← 0, step_done ← 1, go to IDLE.
  - Otherwise: probe_dir ← heading, go to WAIT_CUR.
- WAIT_CUR: go to CHK_CUR.
- CHK_CUR:
  - If can_move = 1 and the bounds check passes: apply step in heading, moving ← 1.
  - Otherwise: moving ← 0.
  - In both cases: step_done ← 1, go to IDLE.
- Step arithmetic per direction:
  - up: pac_y − STEP.
  - down: pac_y + STEP.
  - left: pac_x − STEP.
  - right: pac_x + STEP.
- Bounds check: a step fails if it would make pac_x < 0, pac_x > X_MAX, pac_y < 0 or pac_y > Y_MAX. Compute with one extra bit; no wrap-around. A failed bounds check is treated exactly as can_move = 0.
- move_tick outside IDLE is ignored; it is not queued.
- req_dir changes mid-attempt have no effect. The value latched in IDLE is used for the whole attempt.

## Timing
- Reset values (async, rst = 0):
  - pac_x = X_INIT, pac_y = Y_INIT.
  - probe_dir = 2'b10, heading = 2'b10.
  - moving = 0, busy = 0, step_done = 0.
  - FSM = IDLE.
- Reset asserted mid-attempt aborts the attempt immediately; no partial step is committed.
- Attempt latency, counted from the move_tick cycle (T):
  - Requested direction free: position updates and step_done pulses at edge T+3; back in IDLE at T+3.
  - Fallback to heading: update/pulse at edge T+5.
- busy is high from T+1 until the step_done edge. A move_tick in the cycle after step_done is accepted.
- step_done is high for exactly one cycle per accepted tick.
- pac_x/pac_y change only on a step_done edge, by exactly ±STEP on one axis.
- probe_dir stays at its last value while in IDLE.

## Test plan
- Reset: hold rst = 0 with random inputs → pac_x = 304, pac_y = 224, heading = 2'b10, moving = 0, busy = 0. Release rst; no motion without move_tick.
- Free turn: heading left, req_dir = 00, can_move = 1, pulse move_tick at T → probe_dir = 00 from T+1, step_done at T+3, pac_y = 222, heading = 00, moving = 1.
- Blocked turn, fallback free: heading right, req_dir = 00. Drive can_move = 0 in CHK_REQ and 1 in CHK_CUR → probe_dir goes 00 then 11, step_done at T+5, pac_x = 306, heading stays 11.
- Both blocked: can_move = 0 throughout → step_done at T+5, position unchanged, moving = 0, heading unchanged.
- Boundary: X_INIT = 607, heading right, can_move = 1 → no step (607 + 2 > 608), moving = 0. Same check at pac_y = 1 moving up with STEP = 2 → blocked.
- Tick during busy, and reset mid-attempt: pulse move_tick at T+1 → exactly one step_done. Assert rst at T+2 → outputs at reset values, no step committed.

Source files
------------

// File: rtl/pac_motion_ctrl.sv
// Pac-Man motion controller: probes the wall checker in the requested direction, then in the
// current heading, and commits a bounded STEP-pixel move when the probed direction is free.
module pac_motion_ctrl #(
    parameter int unsigned STEP   = 2,
    parameter int unsigned X_INIT = 304,
    parameter int unsigned Y_INIT = 224,
    parameter int unsigned X_MAX  = 608,
    parameter int unsigned Y_MAX  = 448
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic [1:0] req_dir,
    input  logic       can_move,
    output logic [9:0] pac_x,
    output logic [8:0] pac_y,
    output logic [1:0] probe_dir,
    output logic [1:0] heading,
    output logic       moving,
    output logic       busy,
    output logic       step_done
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_CHK_REQ,
        S_WAIT_CUR,
        S_CHK_CUR
    } state_t;

    state_t          r_state;
    logic [1:0]      r_req;
    logic [XW-1:0]   r_pac_x;
    logic [YW-1:0]   r_pac_y;
    logic [1:0]      r_probe_dir;
    logic [1:0]      r_heading;
    logic            r_moving;
    logic            r_busy;
    logic            r_step_done;

    state_t          w_state_nxt;
    logic [1:0]      w_req_nxt;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic [1:0]      w_probe_nxt;
    logic [1:0]      w_heading_nxt;
    logic            w_moving_nxt;
    logic            w_done_nxt;

    logic [1:0]      w_dir;
    logic [XW:0]     w_x_ext;
    logic [YW:0]     w_y_ext;
    logic            w_in_bounds;
    logic            w_step_ok;

    // Candidate position one step along the direction under test; the extra MSB flags underflow
    always_comb begin
        w_dir   = (r_state == S_CHK_CUR) ? r_heading : r_req;
        w_x_ext = {1'b0, r_pac_x};
        w_y_ext = {1'b0, r_pac_y};
        case (w_dir)
            DIR_UP:    w_y_ext = {1'b0, r_pac_y} - (YW+1)'(STEP);
            DIR_DOWN:  w_y_ext = {1'b0, r_pac_y} + (YW+1)'(STEP);
            DIR_LEFT:  w_x_ext = {1'b0, r_pac_x} - (XW+1)'(STEP);
            DIR_RIGHT: w_x_ext = {1'b0, r_pac_x} + (XW+1)'(STEP);
            default: ;
        endcase
        w_in_bounds = !w_x_ext[XW] && !w_y_ext[YW] &&
                      (w_x_ext <= (XW+1)'(X_MAX)) && (w_y_ext <= (YW+1)'(Y_MAX));
        w_step_ok   = can_move && w_in_bounds;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_x_nxt       = r_pac_x;
        w_y_nxt       = r_pac_y;
        w_probe_nxt   = r_probe_dir;
        w_heading_nxt = r_heading;
        w_moving_nxt  = r_moving;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (move_tick) begin
                    w_probe_nxt = req_dir;
                    w_req_nxt   = req_dir;
                    w_state_nxt = S_WAIT_REQ;
                end
            end
            S_WAIT_REQ: w_state_nxt = S_CHK_REQ;
            S_CHK_REQ: begin
                if (w_step_ok) begin
                    w_heading_nxt = r_req;
                    w_x_nxt       = w_x_ext[XW-1:0];
                    w_y_nxt       = w_y_ext[YW-1:0];
                    w_moving_nxt  = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (r_req == r_heading) begin
                    w_moving_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_probe_nxt = r_heading;
                    w_state_nxt = S_WAIT_CUR;
                end
            end
            S_WAIT_CUR: w_state_nxt = S_CHK_CUR;
            S_CHK_CUR: begin
                if (w_step_ok) begin
                    w_x_nxt      = w_x_ext[XW-1:0];
                    w_y_nxt      = w_y_ext[YW-1:0];
                    w_moving_nxt = 1'b1;
                end else begin
                    w_moving_nxt = 1'b0;
                end
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req       <= DIR_LEFT;
            r_pac_x     <= XW'(X_INIT);
            r_pac_y     <= YW'(Y_INIT);
            r_probe_dir <= DIR_LEFT;
            r_heading   <= DIR_LEFT;
            r_moving    <= 1'b0;
            r_busy      <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_pac_x     <= w_x_nxt;
            r_pac_y     <= w_y_nxt;
            r_probe_dir <= w_probe_nxt;
            r_heading   <= w_heading_nxt;
            r_moving    <= w_moving_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_step_done <= w_done_nxt;
        end
    end

    assign pac_x     = r_pac_x;
    assign pac_y     = r_pac_y;
    assign probe_dir = r_probe_dir;
    assign heading   = r_heading;
    assign moving    = r_moving;
    assign busy      = r_busy;
    assign step_done = r_step_done;

endmodule

// File: tb/tb_pac_motion_ctrl.sv
// Directed bench for pac_motion_ctrl: a default-placed instance for turns/fallback/reset and a
// second instance placed near the right/top edges for the bounds checks.
module tb_pac_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_tick;
    logic       b_tick;
    logic [1:0] req_dir;
    logic       can_move;

    logic [9:0] m_x, b_x;
    logic [8:0] m_y, b_y;
    logic [1:0] m_probe, b_probe, m_head, b_head;
    logic       m_mov, b_mov, m_busy, b_busy, m_done, b_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pac_motion_ctrl u_main (
        .clk(clk), .rst(rst), .move_tick(m_tick), .req_dir(req_dir), .can_move(can_move),
        .pac_x(m_x), .pac_y(m_y), .probe_dir(m_probe), .heading(m_head),
        .moving(m_mov), .busy(m_busy), .step_done(m_done)
    );

    pac_motion_ctrl #(.X_INIT(605), .Y_INIT(3)) u_edge (
        .clk(clk), .rst(rst), .move_tick(b_tick), .req_dir(req_dir), .can_move(can_move),
        .pac_x(b_x), .pac_y(b_y), .probe_dir(b_probe), .heading(b_head),
        .moving(b_mov), .busy(b_busy), .step_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One movement attempt on the selected instance; can_move = c_req up to the CHK_REQ edge,
    // then c_cur. Checks probe/busy along the way and the step_done latency.
    task automatic attempt(input bit sel, input logic [1:0] dir, input bit c_req, input bit c_cur,
                           input int exp_lat, input logic [1:0] fb_dir);
        int n;
        bit seen;
        @(posedge clk); #1;
        req_dir  = dir;
        can_move = c_req;
        if (sel) b_tick = 1'b1; else m_tick = 1'b1;
        @(posedge clk); #1;
        m_tick = 1'b0;
        b_tick = 1'b0;
        req_dir = ~dir;
        n = 1;
        seen = 1'b0;
        chk("probe_req", sel ? b_probe : m_probe, dir);
        chk("busy_start", sel ? b_busy : m_busy, 1);
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) can_move = c_cur;
            seen = sel ? b_done : m_done;
            if (n == 3 && exp_lat == 5) begin
                chk("probe_cur", sel ? b_probe : m_probe, fb_dir);
                chk("busy_mid", sel ? b_busy : m_busy, 1);
            end
        end
        chk("latency", n, exp_lat);
        chk("busy_end", sel ? b_busy : m_busy, 0);
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        m_tick = 1'b0; b_tick = 1'b0; req_dir = 2'b00; can_move = 1'b0;

        // Reset held with random inputs
        repeat (6) begin
            @(negedge clk);
            m_tick = 1'($urandom); b_tick = 1'($urandom);
            req_dir = 2'($urandom); can_move = 1'($urandom);
        end
        @(negedge clk);
        m_tick = 1'b0; b_tick = 1'b0; can_move = 1'b0;
        chk("rst_x", m_x, 304);
        chk("rst_y", m_y, 224);
        chk("rst_head", m_head, 2);
        chk("rst_probe", m_probe, 2);
        chk("rst_mov", m_mov, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_bx", b_x, 605);
        chk("rst_by", b_y, 3);
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_x", m_x, 304);
        chk("idle_done", m_done, 0);
        chk("idle_busy", m_busy, 0);

        // Bounds: right edge and top edge
        attempt(1'b1, 2'b11, 1'b1, 1'b1, 3, 2'b00);
        chk("edge_x1", b_x, 607);
        chk("edge_head1", b_head, 3);
        chk("edge_mov1", b_mov, 1);
        attempt(1'b1, 2'b11, 1'b1, 1'b1, 3, 2'b00);
        chk("edge_x_blk", b_x, 607);
        chk("edge_mov_blk", b_mov, 0);
        attempt(1'b1, 2'b00, 1'b1, 1'b1, 3, 2'b00);
        chk("edge_y1", b_y, 1);
        chk("edge_head_up", b_head, 0);
        attempt(1'b1, 2'b00, 1'b1, 1'b1, 3, 2'b00);
        chk("edge_y_blk", b_y, 1);
        chk("edge_ymov_blk", b_mov, 0);
        chk("edge_x_keep", b_x, 607);
        chk("main_untouched", m_x, 304);

        // Free turn up
        attempt(1'b0, 2'b00, 1'b1, 1'b1, 3, 2'b00);
        chk("turn_y", m_y, 222);
        chk("turn_x", m_x, 304);
        chk("turn_head", m_head, 0);
        chk("turn_mov", m_mov, 1);
        @(posedge clk); #1;
        chk("done_pulse", m_done, 0);

        // Turn right, then blocked turn up with fallback to right
        attempt(1'b0, 2'b11, 1'b1, 1'b1, 3, 2'b00);
        chk("right_x", m_x, 306);
        chk("right_head", m_head, 3);
        attempt(1'b0, 2'b00, 1'b0, 1'b1, 5, 2'b11);
        chk("fb_x", m_x, 308);
        chk("fb_y", m_y, 222);
        chk("fb_head", m_head, 3);
        chk("fb_mov", m_mov, 1);

        // Both blocked
        attempt(1'b0, 2'b00, 1'b0, 1'b0, 5, 2'b11);
        chk("blk_x", m_x, 308);
        chk("blk_y", m_y, 222);
        chk("blk_head", m_head, 3);
        chk("blk_mov", m_mov, 0);

        // Request equals heading and blocked: no fallback probe
        attempt(1'b0, 2'b11, 1'b0, 1'b1, 3, 2'b00);
        chk("same_x", m_x, 308);
        chk("same_mov", m_mov, 0);

        // Down and left arithmetic
        attempt(1'b0, 2'b01, 1'b1, 1'b1, 3, 2'b00);
        chk("down_y", m_y, 224);
        chk("down_head", m_head, 1);
        attempt(1'b0, 2'b10, 1'b1, 1'b1, 3, 2'b00);
        chk("left_x", m_x, 306);
        chk("left_head", m_head, 2);

        // Tick held into the busy cycle: exactly one attempt
        @(posedge clk); #1;
        req_dir = 2'b01; can_move = 1'b1; m_tick = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_tick = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (m_done) cnt++;
        end
        chk("busy_tick_cnt", cnt, 1);
        chk("busy_tick_y", m_y, 226);

        // Reset mid-attempt
        @(posedge clk); #1;
        req_dir = 2'b00; can_move = 1'b1; m_tick = 1'b1;
        @(posedge clk); #1;
        m_tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_x", m_x, 304);
        chk("mid_rst_y", m_y, 224);
        chk("mid_rst_head", m_head, 2);
        chk("mid_rst_probe", m_probe, 2);
        chk("mid_rst_busy", m_busy, 0);
        chk("mid_rst_mov", m_mov, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_done) cnt++;
        end
        chk("mid_rst_nodone", cnt, 0);
        chk("mid_rst_y_hold", m_y, 224);

        // Normal operation after reset
        attempt(1'b0, 2'b00, 1'b1, 1'b1, 3, 2'b00);
        chk("post_rst_y", m_y, 222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
